// File: rtl/iic_cfg_sequencer.sv
// rtl/iic_cfg_sequencer.sv - table-driven IIC configuration sequencer
// Walks a config table and issues one writer transaction per entry, with power-up wait, bus gap and watchdog.
module iic_cfg_sequencer #(
  parameter logic        AUTO_START = 1'b1,
  parameter logic [6:0]  DEV_ADDR   = 7'h48,
  parameter logic [19:0] PWR_DLY    = 20'd500000,
  parameter logic [15:0] GAP_DLY    = 16'd2500,
  parameter logic [19:0] TIMEOUT    = 20'd100000,
  parameter logic [8:0]  TAB_DEPTH  = 9'd32
) (
  input  logic        i_clk_50m,
  input  logic        i_rst,
  input  logic        i_cfg_start,
  output logic [7:0]  o_tab_addr,
  input  logic [35:0] i_tab_data,
  output logic        o_send_en,
  output logic [3:0]  o_send_length,
  output logic [6:0]  o_dev_addr,
  output logic [31:0] o_write_dat,
  input  logic        i_iic_done,
  output logic        o_cfg_busy,
  output logic        o_cfg_done,
  output logic        o_cfg_err,
  output logic [7:0]  o_cfg_count
);

  typedef enum logic [2:0] {
    IDLE,
    PWR_WAIT,
    FETCH,
    LATCH,
    SEND,
    WAIT_DONE,
    GAP,
    FINISH
  } state_t;

  // Terminal values of the shared delay counter; it always starts at 0 on state entry.
  localparam logic [19:0] PWR_LAST = PWR_DLY - 20'd1;
  localparam logic [19:0] GAP_LAST = {4'd0, GAP_DLY} - 20'd1;
  localparam logic [19:0] TO_LAST  = TIMEOUT - 20'd1;

  state_t      state, state_nxt;
  logic [19:0] dly_cnt, dly_cnt_nxt;
  logic [8:0]  index, index_nxt;
  logic [3:0]  send_length_nxt;
  logic [31:0] write_dat_nxt;
  logic        busy_nxt, done_nxt, err_nxt;
  logic [7:0]  count_nxt;

  assign o_tab_addr = index[7:0];
  assign o_dev_addr = DEV_ADDR;
  assign o_send_en  = (state == SEND) && !i_rst;

  always_ff @(posedge i_clk_50m) begin
    if (i_rst) begin
      state         <= AUTO_START ? PWR_WAIT : IDLE;
      dly_cnt       <= '0;
      index         <= '0;
      o_send_length <= '0;
      o_write_dat   <= '0;
      o_cfg_busy    <= 1'b0;
      o_cfg_done    <= 1'b0;
      o_cfg_err     <= 1'b0;
      o_cfg_count   <= '0;
    end else begin
      state         <= state_nxt;
      dly_cnt       <= dly_cnt_nxt;
      index         <= index_nxt;
      o_send_length <= send_length_nxt;
      o_write_dat   <= write_dat_nxt;
      o_cfg_busy    <= busy_nxt;
      o_cfg_done    <= done_nxt;
      o_cfg_err     <= err_nxt;
      o_cfg_count   <= count_nxt;
    end
  end

  always_comb begin
    state_nxt       = state;
    dly_cnt_nxt     = '0;
    index_nxt       = index;
    send_length_nxt = o_send_length;
    write_dat_nxt   = o_write_dat;
    busy_nxt        = o_cfg_busy;
    done_nxt        = o_cfg_done;
    err_nxt         = o_cfg_err;
    count_nxt       = o_cfg_count;

    case (state)
      IDLE: begin
        if (i_cfg_start) begin
          state_nxt = FETCH;
          index_nxt = '0;
          count_nxt = '0;
          done_nxt  = 1'b0;
          err_nxt   = 1'b0;
          busy_nxt  = 1'b1;
        end
      end

      PWR_WAIT: begin
        busy_nxt = 1'b1;
        if (dly_cnt == PWR_LAST) begin
          state_nxt = FETCH;
        end else begin
          dly_cnt_nxt = dly_cnt + 20'd1;
        end
      end

      FETCH: state_nxt = LATCH;

      LATCH: begin
        if (i_tab_data[35:32] == 4'd0) begin
          state_nxt = FINISH;
        end else begin
          send_length_nxt = i_tab_data[35:32];
          write_dat_nxt   = i_tab_data[31:0];
          state_nxt       = SEND;
        end
      end

      SEND: state_nxt = WAIT_DONE;

      // Done takes priority over watchdog expiry on the same clock.
      WAIT_DONE: begin
        if (i_iic_done) begin
          count_nxt = (o_cfg_count == 8'hFF) ? o_cfg_count : o_cfg_count + 8'd1;
          index_nxt = index + 9'd1;
          state_nxt = GAP;
        end else if (dly_cnt == TO_LAST) begin
          err_nxt   = 1'b1;
          busy_nxt  = 1'b0;
          state_nxt = IDLE;
        end else begin
          dly_cnt_nxt = dly_cnt + 20'd1;
        end
      end

      GAP: begin
        if (dly_cnt == GAP_LAST) begin
          state_nxt = (index < TAB_DEPTH) ? FETCH : FINISH;
        end else begin
          dly_cnt_nxt = dly_cnt + 20'd1;
        end
      end

      FINISH: begin
        done_nxt  = 1'b1;
        busy_nxt  = 1'b0;
        state_nxt = IDLE;
      end

      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_iic_cfg_sequencer.sv
// tb/tb_iic_cfg_sequencer.sv - scoreboard bench for iic_cfg_sequencer
// A timeline model predicts every send/done/err event; a negedge monitor pops and compares them.
module tb_iic_cfg_sequencer;

  localparam int         P_PWR   = 10;
  localparam int         P_GAP   = 4;
  localparam int         P_TO    = 50;
  localparam int         P_DEPTH = 4;
  localparam logic [6:0] P_ADDR  = 7'h48;

  localparam logic [1:0] K_SEND = 2'd0;
  localparam logic [1:0] K_DONE = 2'd1;
  localparam logic [1:0] K_ERR  = 2'd2;

  typedef struct packed {
    logic [1:0]  kind;
    logic [31:0] cyc;
    logic [3:0]  len;
    logic [31:0] dat;
    logic [7:0]  cnt;
  } ev_t;

  logic        clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_cfg_start = 1'b0;
  logic        i_iic_done = 1'b0;
  logic [35:0] tab_q = '0;
  logic [7:0]  o_tab_addr;
  logic        o_send_en;
  logic [3:0]  o_send_length;
  logic [6:0]  o_dev_addr;
  logic [31:0] o_write_dat;
  logic        o_cfg_busy, o_cfg_done, o_cfg_err;
  logic [7:0]  o_cfg_count;

  logic [35:0] tab [0:255];
  int          dly [0:P_DEPTH-1];
  ev_t         q[$];
  int          wq[$];
  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;
  bit          mon_en = 1'b0;

  iic_cfg_sequencer #(
    .AUTO_START(1'b1),
    .DEV_ADDR  (P_ADDR),
    .PWR_DLY   (20'(P_PWR)),
    .GAP_DLY   (16'(P_GAP)),
    .TIMEOUT   (20'(P_TO)),
    .TAB_DEPTH (9'(P_DEPTH))
  ) dut (
    .i_clk_50m    (clk),
    .i_rst        (i_rst),
    .i_cfg_start  (i_cfg_start),
    .o_tab_addr   (o_tab_addr),
    .i_tab_data   (tab_q),
    .o_send_en    (o_send_en),
    .o_send_length(o_send_length),
    .o_dev_addr   (o_dev_addr),
    .o_write_dat  (o_write_dat),
    .i_iic_done   (i_iic_done),
    .o_cfg_busy   (o_cfg_busy),
    .o_cfg_done   (o_cfg_done),
    .o_cfg_err    (o_cfg_err),
    .o_cfg_count  (o_cfg_count)
  );

  always #10 clk = ~clk;

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  // Synchronous table ROM: data follows the address by one clock.
  always @(posedge clk) tab_q <= tab[o_tab_addr];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic void push_ev(input logic [1:0] k, input int c, input logic [3:0] l,
                                  input logic [31:0] d, input logic [7:0] n);
    ev_t e;
    e.kind = k;
    e.cyc  = 32'(c);
    e.len  = l;
    e.dat  = d;
    e.cnt  = n;
    q.push_back(e);
  endfunction

  // f0 is the edge after which the sequencer sits in FETCH for entry 0.
  // Observed cycle numbers are the edge after which the output holds.
  task automatic build_expect(input int f0);
    int f, e;
    logic [7:0] cnt;
    f   = f0;
    cnt = 0;
    for (int idx = 0; idx < P_DEPTH; idx++) begin
      if (tab[idx][35:32] == 4'd0) begin
        push_ev(K_DONE, f + 3, 4'd0, 32'd0, cnt);
        return;
      end
      push_ev(K_SEND, f + 2, tab[idx][35:32], tab[idx][31:0], 8'd0);
      wq.push_back(dly[idx]);
      e = f + 3;
      if (dly[idx] == 0) begin
        push_ev(K_ERR, e + P_TO, 4'd0, 32'd0, cnt);
        return;
      end
      cnt++;
      f = e + dly[idx] + P_GAP;
    end
    push_ev(K_DONE, f + 1, 4'd0, 32'd0, cnt);
  endtask

  // Writer model: acks each request after the delay the stimulus queued; 0 means never.
  initial begin
    int d;
    forever begin
      @(negedge clk);
      if (mon_en && !i_rst && o_send_en) begin
        d = (wq.size() > 0) ? wq.pop_front() : 0;
        if (d > 0) begin
          repeat (d) @(posedge clk);
          #1 i_iic_done = 1'b1;
          @(posedge clk);
          #1 i_iic_done = 1'b0;
        end
      end
    end
  end

  initial begin
    ev_t        ev;
    bit         prev_send = 1'b0, prev_done = 1'b0, prev_err = 1'b0, have_last = 1'b0;
    logic [3:0] last_len = '0;
    logic [31:0] last_dat = '0;
    forever begin
      @(negedge clk);
      if (i_rst) have_last = 1'b0;
      if (mon_en && !i_rst) begin
        if (o_send_en) begin
          chk("send_en_single", 64'(prev_send), 64'd0);
          chk("busy_at_send", 64'(o_cfg_busy), 64'd1);
          chk("dev_addr", 64'(o_dev_addr), 64'(P_ADDR));
          if (q.size() == 0) chk("unexpected_send", 64'd1, 64'd0);
          else begin
            ev = q.pop_front();
            chk("send_kind", 64'(ev.kind), 64'(K_SEND));
            chk("send_cycle", 64'(cyc), 64'(ev.cyc));
            chk("send_length", 64'(o_send_length), 64'(ev.len));
            chk("write_dat", 64'(o_write_dat), 64'(ev.dat));
            last_len  = ev.len;
            last_dat  = ev.dat;
            have_last = 1'b1;
          end
        end
        if (i_iic_done && have_last) begin
          chk("len_stable_at_done", 64'(o_send_length), 64'(last_len));
          chk("dat_stable_at_done", 64'(o_write_dat), 64'(last_dat));
        end
        if (o_cfg_done && !prev_done) begin
          if (q.size() == 0) chk("unexpected_done", 64'd1, 64'd0);
          else begin
            ev = q.pop_front();
            chk("done_kind", 64'(ev.kind), 64'(K_DONE));
            chk("done_cycle", 64'(cyc), 64'(ev.cyc));
            chk("done_count", 64'(o_cfg_count), 64'(ev.cnt));
            chk("done_busy", 64'(o_cfg_busy), 64'd0);
            chk("done_err", 64'(o_cfg_err), 64'd0);
          end
        end
        if (o_cfg_err && !prev_err) begin
          if (q.size() == 0) chk("unexpected_err", 64'd1, 64'd0);
          else begin
            ev = q.pop_front();
            chk("err_kind", 64'(ev.kind), 64'(K_ERR));
            chk("err_cycle", 64'(cyc), 64'(ev.cyc));
            chk("err_count", 64'(o_cfg_count), 64'(ev.cnt));
            chk("err_busy", 64'(o_cfg_busy), 64'd0);
            chk("err_done", 64'(o_cfg_done), 64'd0);
          end
        end
      end
      prev_send = o_send_en;
      prev_done = o_cfg_done;
      prev_err  = o_cfg_err;
    end
  end

  task automatic chk_reset();
    chk("rst_send_en", 64'(o_send_en), 64'd0);
    chk("rst_busy", 64'(o_cfg_busy), 64'd0);
    chk("rst_done", 64'(o_cfg_done), 64'd0);
    chk("rst_err", 64'(o_cfg_err), 64'd0);
    chk("rst_count", 64'(o_cfg_count), 64'd0);
    chk("rst_tab_addr", 64'(o_tab_addr), 64'd0);
    chk("rst_send_length", 64'(o_send_length), 64'd0);
    chk("rst_write_dat", 64'(o_write_dat), 64'd0);
    chk("rst_dev_addr", 64'(o_dev_addr), 64'(P_ADDR));
  endtask

  // One-clock reset; returns the last edge that sampled it.
  task automatic rst_pulse(output int r);
    @(posedge clk);
    #1 i_rst = 1'b1;
    q.delete();
    wq.delete();
    @(posedge clk);
    #1 r = cyc;
    i_rst = 1'b0;
    chk_reset();
  endtask

  task automatic run_start();
    @(posedge clk);
    #1 i_cfg_start = 1'b1;
    build_expect(cyc + 1);
    @(posedge clk);
    #1 i_cfg_start = 1'b0;
    chk("start_busy", 64'(o_cfg_busy), 64'd1);
    chk("start_count_clr", 64'(o_cfg_count), 64'd0);
    chk("start_done_clr", 64'(o_cfg_done), 64'd0);
    chk("start_err_clr", 64'(o_cfg_err), 64'd0);
  endtask

  task automatic pulse_start_only();
    @(posedge clk);
    #1 i_cfg_start = 1'b1;
    @(posedge clk);
    #1 i_cfg_start = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    for (int i = 0; i < budget && q.size() > 0; i++) @(posedge clk);
    chk("drain_pending_events", 64'(q.size()), 64'd0);
    chk("writer_queue_empty", 64'(wq.size()), 64'd0);
    q.delete();
    repeat (3) @(posedge clk);
  endtask

  task automatic set_entry(input int i, input logic [3:0] l, input logic [31:0] d);
    tab[i] = {l, d};
  endtask

  initial begin
    #2_000_000;
    failures++;
    $display("FAIL global_timeout actual=running required=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    int r, n;
    for (int i = 0; i < 256; i++) tab[i] = '0;

    // Power-up auto start with an end marker after two entries.
    set_entry(0, 4'd3, 32'h00A1B2C3);
    set_entry(1, 4'd1, 32'h55000000);
    set_entry(2, 4'd0, 32'hDEADBEEF);
    dly[0] = 20; dly[1] = 20; dly[2] = 20; dly[3] = 20;
    repeat (3) @(posedge clk);
    #1 r = cyc;
    i_rst = 1'b0;
    chk_reset();
    build_expect(r + P_PWR);
    mon_en = 1'b1;
    wait_drain(600);

    // Table exhausted without a marker.
    for (int i = 0; i < P_DEPTH; i++) begin
      set_entry(i, 4'd2, 32'h11220000);
      dly[i] = int'($urandom_range(1, 30));
    end
    run_start();
    wait_drain(800);

    // Watchdog expiry on the first entry.
    set_entry(0, 4'd1, 32'hCAFEF00D);
    dly[0] = 0;
    run_start();
    wait_drain(400);

    // Done on the expiry clock; a start while busy must be ignored.
    for (int i = 0; i < P_DEPTH; i++) begin
      set_entry(i, 4'(i + 5), $urandom);
      dly[i] = P_TO;
    end
    run_start();
    repeat (10) @(posedge clk);
    pulse_start_only();
    wait_drain(1000);

    // Reset in the middle of WAIT_DONE, then an auto-started rerun.
    set_entry(0, 4'd4, 32'h01020304);
    set_entry(1, 4'd15, 32'hA5A5A5A5);
    set_entry(2, 4'd0, 32'h0);
    dly[0] = 0;
    run_start();
    repeat (15) @(posedge clk);
    rst_pulse(r);
    dly[0] = 7; dly[1] = 9;
    build_expect(r + P_PWR);
    wait_drain(600);

    // Randomized tables and writer latencies.
    for (int s = 0; s < 10; s++) begin
      n = int'($urandom_range(0, P_DEPTH));
      for (int i = 0; i < P_DEPTH; i++) begin
        tab[i] = {(i < n) ? 4'($urandom_range(1, 15)) : 4'd0, $urandom};
        case ($urandom_range(0, 5))
          0:       dly[i] = 0;
          1:       dly[i] = P_TO;
          default: dly[i] = int'($urandom_range(1, P_TO));
        endcase
      end
      run_start();
      wait_drain(1000);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
